// File: rtl/keypad_decoder_if.sv
// Key event bus between the keypad decoder (master) and its consumer (slave).
// Carries the raw scanner vector in and the queued key codes plus status out.
interface keypad_decoder_if;
  logic [11:0] key_data;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overflow;
  logic        multi_err;
  logic [2:0]  fifo_count;

  modport master (
    input  key_data,
    input  key_ready,
    output key_code,
    output key_valid,
    output key_held,
    output overflow,
    output multi_err,
    output fifo_count
  );

  modport slave (
    output key_data,
    output key_ready,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overflow,
    input  multi_err,
    input  fifo_count
  );
endinterface

// File: rtl/keypad_decoder.sv
// Debounces the one-hot keypad vector on a periodic sample tick and queues one
// 4-bit code per accepted press in a 4-entry FIFO with a valid/ready output.
module keypad_decoder #(
  parameter int unsigned SAMPLE_DIV   = 250000,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  keypad_decoder_if.master bus
);

  localparam int unsigned KEY_W  = 12;
  localparam int unsigned DIV_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned FCNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_CHK,
    S_HELD,
    S_RELEASE_CHK
  } state_t;

  // Key index to user-visible code: 1..9, then * = A, 0 = 0, # = B.
  function automatic logic [CODE_W-1:0] enc(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd9:    enc = 4'hA;
      4'd10:   enc = 4'h0;
      4'd11:   enc = 4'hB;
      default: enc = CODE_W'(idx + 4'd1);
    endcase
  endfunction

  logic [KEY_W-1:0]  r_sync1;
  logic [KEY_W-1:0]  r_sync2;
  logic [DIV_W-1:0]  r_div;
  logic              w_tick;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_cand;
  logic              r_held;
  logic              r_multi_err;

  logic [3:0]        w_ones;
  logic [IDX_W-1:0]  w_idx;
  logic              w_single;
  logic              w_multi;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_db_hit;
  logic              w_push;

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_overflow;

  logic              w_pop;
  logic              w_full;
  logic              w_wr_en;
  logic              w_drop;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [FCNT_W-1:0] w_fcnt_nxt;
  logic [CODE_W-1:0] w_push_code;
  logic [CODE_W-1:0] w_head_nxt;

  // Two-flop synchroniser for the asynchronous scanner vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.key_data;
      r_sync2 <= r_sync1;
    end
  end

  // Sample tick: one clk pulse every SAMPLE_DIV cycles.
  assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Classify the synchronised sample; w_idx is only meaningful when w_single.
  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int i = 0; i < int'(KEY_W); i++) begin
      if (r_sync2[i]) begin
        w_ones = w_ones + 4'd1;
        w_idx  = IDX_W'(i);
      end
    end
  end

  assign w_single  = (w_ones == 4'd1);
  assign w_multi   = (w_ones > 4'd1);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_db_hit  = (w_cnt_inc == CNT_W'(DEBOUNCE_CNT));
  assign w_push    = w_tick && (r_state == S_PRESS_CHK) && w_single &&
                     (w_idx == r_cand) && w_db_hit;

  // Debounce FSM; multi-hot samples fall through the !w_single paths as NONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_held  <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            r_cand  <= w_idx;
            r_cnt   <= CNT_W'(1);
            r_state <= S_PRESS_CHK;
          end
        end
        S_PRESS_CHK: begin
          if (!w_single) begin
            r_state <= S_IDLE;
          end else if (w_idx == r_cand) begin
            r_cnt <= w_cnt_inc;
            if (w_db_hit) begin
              r_state <= S_HELD;
              r_held  <= 1'b1;
            end
          end else begin
            r_cand <= w_idx;
            r_cnt  <= CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!w_single) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_RELEASE_CHK;
          end
        end
        S_RELEASE_CHK: begin
          if (w_single) begin
            r_state <= S_HELD;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_db_hit) begin
              r_state <= S_IDLE;
              r_held  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_multi_err <= 1'b0;
    end else if (w_tick && w_multi) begin
      r_multi_err <= 1'b1;
    end
  end

  // FIFO control: a push into a full queue is accepted only alongside a pop.
  assign w_pop       = r_valid && bus.key_ready;
  assign w_full      = (r_fcnt == FCNT_W'(DEPTH));
  assign w_wr_en     = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_rd_nxt    = w_pop ? (r_rd + PTR_W'(1)) : r_rd;
  assign w_push_code = enc(r_cand);

  always_comb begin
    w_fcnt_nxt = r_fcnt;
    if (w_wr_en && !w_pop) begin
      w_fcnt_nxt = r_fcnt + FCNT_W'(1);
    end else if (!w_wr_en && w_pop) begin
      w_fcnt_nxt = r_fcnt - FCNT_W'(1);
    end
  end

  // Next head word, so key_code comes straight from a flop.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_wr_en && (r_wr == w_rd_nxt)) begin
      w_head_nxt = w_push_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr       <= '0;
      r_rd       <= '0;
      r_fcnt     <= '0;
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= w_push_code;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_rd    <= w_rd_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_valid <= (w_fcnt_nxt != '0);
      r_code  <= w_head_nxt;
    end
  end

  assign bus.key_code   = r_code;
  assign bus.key_valid  = r_valid;
  assign bus.key_held   = r_held;
  assign bus.overflow   = r_overflow;
  assign bus.multi_err  = r_multi_err;
  assign bus.fifo_count = r_fcnt;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: directed scenarios plus random key
// activity, compared every cycle against a run-length based reference model.
`timescale 1ns/1ps
module tb_keypad_decoder;

  localparam int unsigned SDIV     = 4;
  localparam int unsigned DB       = 3;
  localparam int          NONE_CLS = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  keypad_decoder_if bus ();

  keypad_decoder #(
    .SAMPLE_DIV   (SDIV),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a press is a run of DB identical single-key samples while
  // no key is down; a release is a run of DB empty samples while a key is down.
  logic [11:0] m_s1 = '0;
  logic [11:0] m_s2 = '0;
  int unsigned m_e = 0;
  int          m_run_cls = NONE_CLS;
  int unsigned m_run = 0;
  bit          m_down = 0;
  bit          m_ovf = 0;
  bit          m_multi = 0;
  logic [3:0]  m_q[$];

  function automatic logic [3:0] code_of(input int k);
    if (k < 9)   return 4'(k + 1);
    if (k == 9)  return 4'hA;
    if (k == 10) return 4'h0;
    return 4'hB;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit         pop;
    bit         push;
    int         n;
    int         cls;
    logic [3:0] pc;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_e = 0;
      m_run_cls = NONE_CLS; m_run = 0;
      m_down = 0; m_ovf = 0; m_multi = 0;
      m_q.delete();
    end else begin
      pop  = (m_q.size() != 0) && (bus.key_ready == 1'b1);
      push = 0;
      pc   = '0;
      if ((m_e % SDIV) == SDIV - 1) begin
        n = $countones(m_s2);
        if (n > 1) m_multi = 1;
        cls = NONE_CLS;
        if (n == 1) begin
          for (int i = 0; i < 12; i++) if (m_s2[i]) cls = i;
        end
        if (cls == m_run_cls) m_run++;
        else begin
          m_run_cls = cls;
          m_run = 1;
        end
        if (!m_down && cls != NONE_CLS && m_run == DB) begin
          push = 1;
          pc = code_of(cls);
          m_down = 1;
        end else if (m_down && cls == NONE_CLS && m_run == DB) begin
          m_down = 0;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < 4) m_q.push_back(pc);
        else m_ovf = 1;
      end
      m_s2 = m_s1;
      m_s1 = bus.key_data;
      m_e++;
    end
  end

  // Record every code the consumer actually accepts.
  logic [3:0] got[$];
  always @(posedge clk) begin
    if (rst === 1'b1 && bus.key_valid === 1'b1 && bus.key_ready === 1'b1)
      got.push_back(bus.key_code);
  end

  task automatic cmp_model();
    chk("valid", 32'(bus.key_valid), 32'(m_q.size() != 0));
    chk("count", 32'(bus.fifo_count), 32'(m_q.size()));
    if (m_q.size() != 0) chk("code", 32'(bus.key_code), 32'(m_q[0]));
    chk("held", 32'(bus.key_held), 32'(m_down));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("multi_err", 32'(bus.multi_err), 32'(m_multi));
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  task automatic hold(input logic [11:0] v, input int unsigned ticks);
    bus.key_data = v;
    step(ticks * SDIV);
  endtask

  task automatic chk_events(input string tag, input int unsigned base,
                            input logic [3:0] exp[$]);
    chk({tag, "_n"}, 32'(got.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < got.size()) chk({tag, "_code"}, 32'(got[base + i]), 32'(exp[i]));
    end
  endtask

  logic [11:0] t3_keys[5] = '{12'h200, 12'h400, 12'h800, 12'h040, 12'h002};

  initial begin
    int unsigned base;
    logic [11:0] v;
    bus.key_data  = '0;
    bus.key_ready = 1'b1;

    // Reset state
    #22;
    chk("rst_valid", 32'(bus.key_valid), 0);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_held", 32'(bus.key_held), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_multi", 32'(bus.multi_err), 0);
    chk("rst_code", 32'(bus.key_code), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: single press of key 5
    base = got.size();
    hold(12'h010, 2);
    chk("t1_held_early", 32'(bus.key_held), 0);
    hold(12'h010, 1);
    chk("t1_held", 32'(bus.key_held), 1);
    hold(12'h010, 2);
    hold(12'h000, 2);
    chk("t1_held_rel2", 32'(bus.key_held), 1);
    hold(12'h000, 1);
    chk("t1_released", 32'(bus.key_held), 0);
    hold(12'h000, 1);
    chk_events("t1", base, '{4'h5});

    // 2: bounce before a clean press
    base = got.size();
    hold(12'h001, 2);
    hold(12'h000, 1);
    hold(12'h001, 3);
    hold(12'h000, 4);
    chk_events("t2", base, '{4'h1});

    // 3: fill the queue with the consumer stalled, then drain
    base = got.size();
    bus.key_ready = 1'b0;
    foreach (t3_keys[i]) begin
      hold(t3_keys[i], 4);
      hold(12'h000, 4);
    end
    chk("t3_count", 32'(bus.fifo_count), 4);
    chk("t3_ovf", 32'(bus.overflow), 1);
    chk("t3_head", 32'(bus.key_code), 32'hA);
    bus.key_ready = 1'b1;
    step(8);
    chk("t3_empty", 32'(bus.key_valid), 0);
    chk_events("t3", base, '{4'hA, 4'h0, 4'hB, 4'h7});

    // 4: multi-hot sample
    base = got.size();
    hold(12'h003, 4);
    chk("t4_multi", 32'(bus.multi_err), 1);
    chk("t4_held", 32'(bus.key_held), 0);
    hold(12'h000, 4);
    chk("t4_events", 32'(got.size() - base), 0);

    // 5: no rollover while held
    base = got.size();
    hold(12'h800, 4);
    hold(12'h040, 4);
    chk("t5_held", 32'(bus.key_held), 1);
    hold(12'h000, 4);
    hold(12'h040, 4);
    hold(12'h000, 4);
    chk_events("t5", base, '{4'hB, 4'h7});

    // 6: asynchronous reset with events queued and a press in progress
    bus.key_ready = 1'b0;
    hold(12'h001, 4);
    hold(12'h000, 4);
    hold(12'h002, 4);
    hold(12'h000, 4);
    chk("t6_count", 32'(bus.fifo_count), 2);
    hold(12'h004, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.key_valid), 0);
    chk("t6_count0", 32'(bus.fifo_count), 0);
    chk("t6_ovf", 32'(bus.overflow), 0);
    chk("t6_multi", 32'(bus.multi_err), 0);
    chk("t6_held", 32'(bus.key_held), 0);
    @(negedge clk);
    rst = 1'b1;
    bus.key_ready = 1'b1;
    base = got.size();
    hold(12'h000, 2);
    hold(12'h004, 4);
    hold(12'h000, 4);
    chk_events("t6", base, '{4'h3});

    // Random key activity, not aligned to the sample tick
    for (int s = 0; s < 220; s++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 4) v = '0;
      else if (r < 9) v = 12'(1) << $urandom_range(0, 11);
      else v = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      bus.key_data  = v;
      bus.key_ready = ($urandom_range(0, 3) != 0);
      step($urandom_range(1, 24));
    end
    bus.key_data  = '0;
    bus.key_ready = 1'b1;
    step(40);
    chk("final_empty", 32'(bus.key_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
